// File: rtl/uart_tx.sv
// UART transmitter: serializes one byte per accept into start, 8 data bits LSB first,
// optional parity and one stop bit; each bit lasts Prescale clocks (0 treated as 1).
// Latency: S_Data=0 and busy=1 are visible right after the accept edge. Data_valid is
// ignored while busy; there is no queueing, so the sender retries once busy drops.
//
// Ports:
//   CLK, Reset            rising-edge clock, asynchronous active-high reset
//   P_Data, Data_valid    byte to send and its request, sampled only in IDLE
//   Parity_EN/Parity_type parity enable and type (0 = even, 1 = odd), sampled at accept
//   Prescale              clocks per bit, sampled at accept
//   S_Data, busy          registered serial line (idles high) and frame-in-flight flag
module uart_tx (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] P_Data,
    input  logic       Data_valid,
    input  logic       Parity_EN,
    input  logic       Parity_type,
    input  logic [4:0] Prescale,
    output logic       S_Data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] data;
    logic       par_en;
    logic       par_type;
    logic [4:0] last;      // final count value of each bit: max(Prescale,1)-1
    logic [4:0] cnt;
    logic [2:0] bit_idx;

    logic       bit_end;
    logic       par_bit;
    logic [2:0] next_idx;

    assign bit_end  = (cnt == last);
    assign par_bit  = par_type ? ~^data : ^data;
    assign next_idx = bit_idx + 3'd1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            S_Data   <= 1'b1;
            busy     <= 1'b0;
            data     <= 8'h00;
            par_en   <= 1'b0;
            par_type <= 1'b0;
            last     <= 5'd0;
            cnt      <= 5'd0;
            bit_idx  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= 5'd0;
                    bit_idx <= 3'd0;
                    S_Data  <= 1'b1;
                    busy    <= 1'b0;
                    if (Data_valid) begin
                        data     <= P_Data;
                        par_en   <= Parity_EN;
                        par_type <= Parity_type;
                        last     <= (Prescale == 5'd0) ? 5'd0 : (Prescale - 5'd1);
                        state    <= START;
                        S_Data   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt     <= 5'd0;
                        bit_idx <= 3'd0;
                        S_Data  <= data[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt <= 5'd0;
                        if (bit_idx == 3'd7) begin
                            if (par_en) begin
                                S_Data <= par_bit;
                                state  <= PARITY;
                            end else begin
                                S_Data <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= next_idx;
                            S_Data  <= data[next_idx];
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        cnt    <= 5'd0;
                        S_Data <= 1'b1;
                        state  <= STOP;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt    <= 5'd0;
                        S_Data <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    S_Data <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the serializing counterpart of the system's UART receiver. Accepts one 8-bit parallel byte per handshake and drives a standard asynchronous frame (start, 8 data bits LSB first, optional parity, one stop) onto the serial line. Bit period is Prescale clock cycles. This matches the receiver's oversampling ratio, so both ends share one clock and one Prescale setting.

## Interface
- No parameters; data width fixed at 8, one stop bit.
- CLK  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- P_Data  input  8  byte to send; sampled on the accept edge only.
- Data_valid  input  1  request to send P_Data; honoured only in IDLE.
- Parity_EN  input  1  1 = parity bit inserted after data; sampled on the accept edge.
- Parity_type  input  1  0 = even, 1 = odd; sampled on the accept edge.
- Prescale  input  5  clock cycles per bit; sampled on the accept edge; 0 is treated as 1.
- S_Data  output  1  serial line, registered; idles high.
- busy  output  1  registered; high from the accept edge until the frame ends.

## Operation
- States:
  - IDLE: S_Data=1, busy=0. Data_valid=1 at an edge → latch P_Data, Parity_EN, Parity_type and P=max(Prescale,1). Go to START with S_Data=0, busy=1.
  - START: hold S_Data=0 for P cycles, then go to DATA with bit 0.
  - DATA: send P_Data[0]..P_Data[7], each for P cycles, using a 3-bit bit index. After bit 7: go to PARITY if parity is enabled, else STOP.
  - PARITY: send the parity bit for P cycles, then go to STOP.
    - Even parity: bit = ^data.
    - Odd parity: bit = ~^data.
  - STOP: S_Data=1 for P cycles, then go to IDLE with busy=0.
- Cycle counter: 5 bits, counts 0..P-1 within each bit; it wraps to 0 on every bit transition.
- Data_valid while busy=1 is ignored. No queueing, no error flag.
- Changes to P_Data, Parity_EN, Parity_type or Prescale mid-frame have no effect on the frame in flight.
- Outputs are driven only from registers; there is no combinational path from any input to S_Data or busy.

## Timing
- Reset (asynchronous assert): S_Data=1, busy=0, state IDLE, counters 0.
  - Takes effect immediately, including mid-frame; the line returns high with no stop bit.
  - Deassertion is synchronized by the user; the first accept can occur at the first edge after release.
- Accept at edge N:
  - S_Data=0 and busy=1 are visible after edge N.
  - Bit k of the frame (k=0 is start) occupies edges N+k·P to N+(k+1)·P.
- Frame length F: 10 bits without parity, 11 bits with parity.
- busy falls and S_Data stays 1 at edge N+F·P.
- The earliest next accept is edge N+F·P+1, so there is a minimum of one extra idle-high cycle between back-to-back frames.
- P=1: each bit lasts exactly one clock and the frame is F clocks long.
- P=31 (maximum): the counter must reach 30 without overflow; each bit lasts 31 clocks.

## Test plan
- Prescale=8, Parity_EN=1, Parity_type=0, P_Data=0xD5:
  - S_Data sequence, 8 clocks per bit: 0,1,0,1,0,1,0,1,1,1(parity: five ones → even bit 1),1.
  - busy high for exactly 88 cycles.
- Parity_type=1, P_Data=0xFF, Prescale=8:
  - Parity bit = 1 (eight ones, odd).
  - Frame is 11 bits; the stop bit is high.
- Parity_EN=0, P_Data=0x55, Prescale=8:
  - Frame is 10 bits: 0,1,0,1,0,1,0,1,0,1.
  - busy falls at 80 cycles.
- Data_valid held high continuously with P_Data=0xA0 then 0x0F, Prescale=4:
  - Two frames of 44 cycles each, separated by exactly one idle-high cycle.
  - Data_valid pulses during busy are ignored, and the second frame carries the value present at its own accept edge.
- Reset asserted at cycle 30 of a Prescale=8 frame:
  - S_Data=1 and busy=0 immediately.
  - After release, a new accept of 0x3C produces a complete, correct frame.
- Prescale=0 and Prescale=1 with P_Data=0x01, parity off:
  - Both produce a 10-cycle frame 0,1,0,0,0,0,0,0,0,1.
